i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_pkg.sv | 14 +
 rtl/i2s_rx_if.sv | 25 ++
 rtl/i2s_rx_sync2.sv | 19 +
 rtl/i2s_rx.sv | 147 ++++++++++++++
 tb/tb_i2s_rx.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions: receiver state encoding and I2S framing modes.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  // MSB offset from the lrck edge, in bclk periods
  localparam int unsigned I2S_DELAY_LJ      = 0;
  localparam int unsigned I2S_DELAY_PHILIPS = 1;

endpackage

// File: rtl/i2s_rx_if.sv
// Serial I2S inputs and parallel sample outputs of the receiver.
interface i2s_rx_if #(
  parameter int unsigned DATA_W = 16
);

  logic              i2s_bclk;
  logic              i2s_lrck;
  logic              i2s_din;
  logic [DATA_W-1:0] audio_l;
  logic [DATA_W-1:0] audio_r;
  logic              audio_valid;
  logic              locked;
  logic              frame_err;

  modport slave (
    input  i2s_bclk, i2s_lrck, i2s_din,
    output audio_l, audio_r, audio_valid, locked, frame_err
  );

  modport master (
    output i2s_bclk, i2s_lrck, i2s_din,
    input  audio_l, audio_r, audio_valid, locked, frame_err
  );

endinterface

// File: rtl/i2s_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module i2s_rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // shift the asynchronous input through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= '0;
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/i2s_rx.sv
// I2S / left-justified stereo receiver, oversampling bclk in the clk domain.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DELAY   = I2S_DELAY_LJ,
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  i2s_rx_if.slave i2s
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + DELAY + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LO_C   = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DATA_W + DELAY);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(DATA_W + DELAY - 1);
  localparam logic [IDLE_W-1:0] TO_C   = IDLE_W'(TIMEOUT);

  logic bclk_s, lrck_s, din_s;

  i2s_rx_sync2 u_sync_bclk (.clk(clk), .rst(rst), .d_i(i2s.i2s_bclk), .q_o(bclk_s));
  i2s_rx_sync2 u_sync_lrck (.clk(clk), .rst(rst), .d_i(i2s.i2s_lrck), .q_o(lrck_s));
  i2s_rx_sync2 u_sync_din  (.clk(clk), .rst(rst), .d_i(i2s.i2s_din),  .q_o(din_s));

  rx_state_e         state_q, state_d;
  logic              bclk_prev_q, bclk_prev_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] audio_l_q, audio_l_d;
  logic [DATA_W-1:0] audio_r_q, audio_r_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

  logic              sample;
  logic [CNT_W-1:0]  k;

  assign sample = bclk_prev_q & ~bclk_s;

  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // next state, bit capture, sample assembly and lock tracking
  always_comb begin
    state_d     = state_q;
    bclk_prev_d = bclk_s;
    lrck_prev_d = lrck_prev_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    shreg_d     = shreg_q;
    hold_l_d    = hold_l_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    k           = cnt_q;

    if (sample) begin
      idle_d      = '0;
      lrck_prev_d = lrck_s;
      if (lrck_s != lrck_prev_q) begin
        k = '0;
        unique case (state_q)
          SYNC:  if (!lrck_s) state_d = LEFT;
          LEFT:  if (lrck_s) begin
                   if (cnt_q == FULL_C) begin
                     hold_l_d = shreg_q;
                     state_d  = RIGHT;
                   end else begin
                     err_d   = 1'b1;
                     state_d = SYNC;
                   end
                 end
          RIGHT: if (!lrck_s) begin
                   state_d = LEFT;
                   if (cnt_q != FULL_C) err_d = 1'b1;
                 end
          default: state_d = SYNC;
        endcase
      end

      if (k < FULL_C) cnt_d = k + 1'b1;
      else            cnt_d = k;

      // the bit at a slot start already belongs to the new slot, hence state_d
      if (state_d != SYNC && ((k > LO_C) || (k == LO_C)) && k < FULL_C) begin
        shreg_d = {shreg_q[DATA_W-2:0], din_s};
        if (state_d == RIGHT && k == LAST_C) begin
          audio_l_d = hold_l_q;
          audio_r_d = shreg_d;
          valid_d   = 1'b1;
          locked_d  = 1'b1;
        end
      end
    end else if (idle_q == TO_C) begin
      state_d  = SYNC;
      locked_d = 1'b0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      cnt_q       <= '0;
      idle_q      <= '0;
      shreg_q     <= '0;
      hold_l_q    <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      shreg_q     <= shreg_d;
      hold_l_q    <= hold_l_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign i2s.audio_l     = audio_l_q;
  assign i2s.audio_r     = audio_r_q;
  assign i2s.audio_valid = valid_q;
  assign i2s.locked      = locked_q;
  assign i2s.frame_err   = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: left-justified (dut0) and Philips (dut1) framing.
module tb_i2s_rx;

  logic clk, rst, bclk, lrck, din;
  int   checks, failures;
  int   nv0, ne0, nv1, ne1;
  int   v0, e0, v1, e1;

  i2s_rx_if #(.DATA_W(16)) if0 ();
  i2s_rx_if #(.DATA_W(16)) if1 ();

  assign if0.i2s_bclk = bclk;
  assign if0.i2s_lrck = lrck;
  assign if0.i2s_din  = din;
  assign if1.i2s_bclk = bclk;
  assign if1.i2s_lrck = lrck;
  assign if1.i2s_din  = din;

  i2s_rx #(.DATA_W(16), .DELAY(0), .TIMEOUT(255)) dut0 (.clk(clk), .rst(rst), .i2s(if0));
  i2s_rx #(.DATA_W(16), .DELAY(1), .TIMEOUT(255)) dut1 (.clk(clk), .rst(rst), .i2s(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe counters, sampled away from the active edge
  always @(negedge clk) begin
    if (if0.audio_valid) nv0 <= nv0 + 1;
    if (if0.frame_err)   ne0 <= ne0 + 1;
    if (if1.audio_valid) nv1 <= nv1 + 1;
    if (if1.frame_err)   ne1 <= ne1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one bclk period of 21 clk; the receiver samples on the falling edge
  task automatic send_bit(input logic l, input logic d);
    bclk = 1'b1;
    lrck = l;
    din  = d;
    tick(10);
    bclk = 1'b0;
    tick(11);
  endtask

  task automatic send_slot(input logic l, input logic [15:0] w, input int n, input int dly);
    for (int k = 0; k < n; k++) begin
      logic b;
      if (k >= dly && k < dly + 16) b = w[15-(k-dly)];
      else                          b = k[0];
      send_bit(l, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n, input int dly);
    send_slot(1'b0, l, n, dly);
    send_slot(1'b1, r, n, dly);
    tick(5);
  endtask

  initial begin
    checks = 0; failures = 0;
    nv0 = 0; ne0 = 0; nv1 = 0; ne1 = 0;
    rst = 1'b1; bclk = 1'b0; lrck = 1'b0; din = 1'b0;
    tick(3);
    check("rst_l",      32'(if0.audio_l),     32'h0);
    check("rst_r",      32'(if0.audio_r),     32'h0);
    check("rst_valid",  32'(if0.audio_valid), 32'h0);
    check("rst_locked", 32'(if0.locked),      32'h0);
    check("rst_err",    32'(if0.frame_err),   32'h0);
    check("rst1_valid", 32'(if1.audio_valid), 32'h0);
    check("rst1_locked",32'(if1.locked),      32'h0);
    rst = 1'b0;
    tick(5);

    // stream joins in the middle of a right slot
    v0 = nv0; e0 = ne0;
    send_slot(1'b1, 16'hFFFF, 7, 0);
    tick(5);
    check("mid_valid", 32'(nv0 - v0), 32'd0);
    check("mid_err",   32'(ne0 - e0), 32'd0);
    send_frame(16'h8001, 16'h7FFE, 16, 0);
    check("f1_count",  32'(nv0 - v0), 32'd1);
    check("f1_l",      32'(if0.audio_l), 32'h8001);
    check("f1_r",      32'(if0.audio_r), 32'h7FFE);
    check("f1_locked", 32'(if0.locked),  32'h1);
    send_frame(16'h1234, 16'hFEDC, 16, 0);
    check("f2_count",  32'(nv0 - v0), 32'd2);
    check("f2_l",      32'(if0.audio_l), 32'h1234);
    check("f2_r",      32'(if0.audio_r), 32'hFEDC);
    check("f2_err",    32'(ne0 - e0),    32'd0);

    // left slot truncated to 10 bits
    v0 = nv0; e0 = ne0;
    send_slot(1'b0, 16'h5555, 10, 0);
    send_slot(1'b1, 16'h3333, 16, 0);
    tick(5);
    check("trunc_err",   32'(ne0 - e0), 32'd1);
    check("trunc_valid", 32'(nv0 - v0), 32'd0);
    check("trunc_hold_l",32'(if0.audio_l), 32'h1234);
    send_frame(16'hC003, 16'h3FFC, 16, 0);
    check("recov_count", 32'(nv0 - v0), 32'd1);
    check("recov_l",     32'(if0.audio_l), 32'hC003);
    check("recov_r",     32'(if0.audio_r), 32'h3FFC);
    check("recov_err",   32'(ne0 - e0),    32'd1);

    // bclk stops for 300 clk cycles
    v0 = nv0; e0 = ne0;
    tick(200);
    check("idle_locked_200", 32'(if0.locked), 32'h1);
    tick(100);
    check("idle_locked_300", 32'(if0.locked), 32'h0);
    check("idle_valid",      32'(nv0 - v0),   32'd0);
    check("idle_err",        32'(ne0 - e0),   32'd0);
    send_frame(16'h4321, 16'h1357, 16, 0);
    check("restart_count",  32'(nv0 - v0),     32'd1);
    check("restart_locked", 32'(if0.locked),   32'h1);
    check("restart_l",      32'(if0.audio_l),  32'h4321);
    check("restart_r",      32'(if0.audio_r),  32'h1357);
    check("restart_err",    32'(ne0 - e0),     32'd0);

    // reset in the middle of a left slot
    send_slot(1'b0, 16'hAAAA, 8, 0);
    rst = 1'b1;
    tick(2);
    check("mrst_l",      32'(if0.audio_l),     32'h0);
    check("mrst_r",      32'(if0.audio_r),     32'h0);
    check("mrst_locked", 32'(if0.locked),      32'h0);
    check("mrst_valid",  32'(if0.audio_valid), 32'h0);
    rst = 1'b0;
    tick(3);
    v0 = nv0; e0 = ne0;
    send_slot(1'b1, 16'h9999, 16, 0);
    tick(5);
    check("mrst_pre_valid", 32'(nv0 - v0), 32'd0);
    send_frame(16'h0F0F, 16'hF0F0, 16, 0);
    check("mrst_count", 32'(nv0 - v0),    32'd1);
    check("mrst_new_l", 32'(if0.audio_l), 32'h0F0F);
    check("mrst_new_r", 32'(if0.audio_r), 32'hF0F0);
    check("mrst_err",   32'(ne0 - e0),    32'd0);

    // Philips framing, 32-bit slots with trailing junk
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    v1 = nv1; e1 = ne1;
    send_slot(1'b1, 16'hFFFF, 5, 1);
    send_frame(16'hA5A5, 16'h5A5A, 32, 1);
    check("ph_count",  32'(nv1 - v1),    32'd1);
    check("ph_l",      32'(if1.audio_l), 32'hA5A5);
    check("ph_r",      32'(if1.audio_r), 32'h5A5A);
    check("ph_locked", 32'(if1.locked),  32'h1);
    send_frame(16'h0001, 16'hFFFE, 32, 1);
    check("ph2_count", 32'(nv1 - v1),    32'd2);
    check("ph2_l",     32'(if1.audio_l), 32'h0001);
    check("ph2_r",     32'(if1.audio_r), 32'hFFFE);
    check("ph_err",    32'(ne1 - e1),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
